vend_credit_ctrl: RTL and testbench

- Moore-type front-end controller of the vending machine.
- Accumulates coin credit, accepts a product selection and drives the dispense request (C, K) into the Mealy dispense stage.
- Treats the returned A as its acknowledge, then issues change or refund.
- All outputs are registered and depend on state only.

---
 rtl/vend_credit_ctrl.sv | 165 ++++++++++++++++
 tb/tb_vend_credit_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vend_credit_ctrl.sv
// Vending front-end: collects coin credit, hands a selection to the dispense stage, then refunds change.
// Optional SALES_COUNTER_EN macro adds the sales_cnt output (successful vends, wraps at 255).
module vend_credit_ctrl #(
   parameter int MAX_CREDIT   = 5,
   parameter int IDLE_TIMEOUT = 200,
   parameter int ACK_TIMEOUT  = 15
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       coin_valid,
   input  logic [1:0] coin_val,
   input  logic       sel_valid,
   input  logic [2:0] sel_code,
   input  logic       cancel,
   input  logic       A,
   output logic [2:0] C,
   output logic       K,
   output logic       refund_valid,
   output logic [2:0] refund_amt,
   output logic       coin_reject,
   output logic       fault,
`ifdef SALES_COUNTER_EN
   output logic [7:0] sales_cnt,
`endif
   output logic       busy
);

   localparam int IW = $clog2(IDLE_TIMEOUT + 1);
   localparam int AW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISPENSE, S_REFUND} state_t;

   state_t          r_state;
   logic [2:0]      r_credit;
   logic [2:0]      r_code;
   logic [IW-1:0]   r_idle_cnt;
   logic [AW-1:0]   r_ack_cnt;

   state_t          w_nstate;
   logic [2:0]      w_ncredit;
   logic [2:0]      w_ncode;
   logic [IW-1:0]   w_nidle;
   logic [AW-1:0]   w_nack;
   logic            w_nfault;
   logic            w_reject;

   logic [2:0]      w_coin_units;
   logic            w_coin_ok;
   logic [3:0]      w_sum;
   logic            w_fits;
   logic            w_sel_ok;

   assign w_coin_units = (coin_val == 2'b01) ? 3'd1 :
                         (coin_val == 2'b10) ? 3'd2 : 3'd0;
   assign w_coin_ok    = coin_valid && (w_coin_units != 3'd0);
   assign w_sum        = {1'b0, r_credit} + {1'b0, w_coin_units};
   assign w_fits       = (w_sum <= 4'(MAX_CREDIT));
   assign w_sel_ok     = sel_valid && (sel_code >= 3'd1) && (sel_code <= 3'd5) &&
                         (sel_code <= r_credit);

   always_comb begin
      w_nstate  = r_state;
      w_ncredit = r_credit;
      w_ncode   = r_code;
      w_nidle   = r_idle_cnt;
      w_nack    = r_ack_cnt;
      w_nfault  = fault;
      w_reject  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_coin_ok && w_fits) begin
               w_ncredit = w_sum[2:0];
               w_nidle   = '0;
               w_nstate  = S_COLLECT;
            end else if (coin_valid) begin
               w_reject = 1'b1;
            end
         end
         S_COLLECT: begin
            // A coin landing with an accepted cancel/select is dropped, not credited.
            if (cancel) begin
               w_reject = coin_valid;
               w_nstate = S_REFUND;
            end else if (w_sel_ok) begin
               w_reject = coin_valid;
               w_ncode  = sel_code;
               w_nack   = '0;
               w_nstate = S_DISPENSE;
            end else if (w_coin_ok && w_fits) begin
               w_ncredit = w_sum[2:0];
               w_nidle   = '0;
            end else begin
               w_reject = coin_valid;
               if (r_idle_cnt == IW'(IDLE_TIMEOUT - 1))
                  w_nstate = S_REFUND;
               else
                  w_nidle = r_idle_cnt + IW'(1);
            end
         end
         S_DISPENSE: begin
            w_reject = coin_valid;
            if (A) begin
               w_ncredit = r_credit - r_code;
               w_nstate  = S_REFUND;
            end else if (r_ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
               w_nfault = 1'b1;
               w_nstate = S_REFUND;
            end else begin
               w_nack = r_ack_cnt + AW'(1);
            end
         end
         default: begin
            w_reject  = coin_valid;
            w_ncredit = 3'd0;
            w_nstate  = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from next-state values so they line up with the state they describe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_credit     <= 3'd0;
         r_idle_cnt   <= '0;
         r_ack_cnt    <= '0;
         fault        <= 1'b0;
         C            <= 3'd0;
         K            <= 1'b0;
         refund_valid <= 1'b0;
         refund_amt   <= 3'd0;
         coin_reject  <= 1'b0;
         busy         <= 1'b0;
      end else begin
         r_state      <= w_nstate;
         r_credit     <= w_ncredit;
         r_idle_cnt   <= w_nidle;
         r_ack_cnt    <= w_nack;
         fault        <= w_nfault;
         C            <= (w_nstate == S_DISPENSE) ? w_ncode : w_ncredit;
         K            <= (w_nstate == S_DISPENSE);
         refund_valid <= (w_nstate == S_REFUND) && (w_ncredit != 3'd0);
         refund_amt   <= (w_nstate == S_REFUND) ? w_ncredit : 3'd0;
         coin_reject  <= w_reject;
         busy         <= (w_nstate == S_DISPENSE) || (w_nstate == S_REFUND);
      end
   end

   always_ff @(posedge clk) begin
      r_code <= w_ncode;
   end

`ifdef SALES_COUNTER_EN
   logic w_sale;
   assign w_sale = (r_state == S_DISPENSE) && A;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         sales_cnt <= 8'd0;
      else if (w_sale)
         sales_cnt <= sales_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Directed bench for vend_credit_ctrl with a one-cycle-latency acknowledge model.
module tb_vend_credit_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       coin_valid = 1'b0;
   logic [1:0] coin_val = 2'b00;
   logic       sel_valid = 1'b0;
   logic [2:0] sel_code = 3'd0;
   logic       cancel = 1'b0;
   logic       A;
   logic [2:0] C;
   logic       K;
   logic       refund_valid;
   logic [2:0] refund_amt;
   logic       coin_reject;
   logic       fault;
   logic       busy;
`ifdef SALES_COUNTER_EN
   logic [7:0] sales_cnt;
`endif

   int n_chk = 0;
   int n_err = 0;
   logic a_en = 1'b1;
   logic a_q;

   always #5 clk = ~clk;

   // Dispense stage answers one cycle after seeing K.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) a_q <= 1'b0;
      else          a_q <= K;
   end
   assign A = a_en & a_q;

   vend_credit_ctrl dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .coin_valid   (coin_valid),
      .coin_val     (coin_val),
      .sel_valid    (sel_valid),
      .sel_code     (sel_code),
      .cancel       (cancel),
      .A            (A),
      .C            (C),
      .K            (K),
      .refund_valid (refund_valid),
      .refund_amt   (refund_amt),
      .coin_reject  (coin_reject),
      .fault        (fault),
`ifdef SALES_COUNTER_EN
      .sales_cnt    (sales_cnt),
`endif
      .busy         (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      coin_valid = 1'b0;
      sel_valid  = 1'b0;
      cancel     = 1'b0;
   endtask

   task automatic put_coin(input logic [1:0] v);
      coin_valid = 1'b1;
      coin_val   = v;
      tick();
   endtask

   task automatic select(input logic [2:0] code);
      sel_valid = 1'b1;
      sel_code  = code;
      tick();
   endtask

   int kcnt;
   int n;
   logic seen;

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_C", C, 0);
      check("rst_K", K, 0);
      check("rst_rv", refund_valid, 0);
      check("rst_ra", refund_amt, 0);
      check("rst_rej", coin_reject, 0);
      check("rst_fault", fault, 0);
      check("rst_busy", busy, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Invalid coin in IDLE
      put_coin(2'b11);
      check("idle_bad_rej", coin_reject, 1);
      check("idle_bad_C", C, 0);

      // 2+2+1, select 5 -> exact price, no change strobe
      put_coin(2'b10); check("t1_c2", C, 2);
      put_coin(2'b10); check("t1_c4", C, 4);
      put_coin(2'b01); check("t1_c5", C, 5);
      select(3'd5);
      check("t1_K1", K, 1); check("t1_C", C, 5); check("t1_busy", busy, 1);
      tick();
      check("t1_K2", K, 1);
      tick();
      check("t1_K3", K, 0); check("t1_rv", refund_valid, 0); check("t1_busyR", busy, 1);
      tick();
      check("t1_idle_busy", busy, 0); check("t1_idle_C", C, 0);

      // 2+2, select 3 -> change 1; coin during dispense refused
      put_coin(2'b10); put_coin(2'b10);
      select(3'd3);
      check("t2_C", C, 3); check("t2_K1", K, 1);
      coin_valid = 1'b1; coin_val = 2'b01;
      tick();
      check("t2_K2", K, 1); check("t2_disp_rej", coin_reject, 1);
      tick();
      check("t2_rv", refund_valid, 1); check("t2_ra", refund_amt, 1); check("t2_K3", K, 0);
`ifdef SALES_COUNTER_EN
      check("t2_sales", sales_cnt, 2);
`endif
      tick();
      check("t2_rv_end", refund_valid, 0); check("t2_C_end", C, 0);

      // Overflowing coin refused, unaffordable select ignored, then cancel
      put_coin(2'b10); put_coin(2'b10);
      put_coin(2'b10);
      check("t3_rej", coin_reject, 1); check("t3_C4", C, 4);
      tick();
      check("t3_rej_off", coin_reject, 0);
      select(3'd5);
      check("t3_noK", K, 0); check("t3_C_keep", C, 4);
      select(3'd7);
      check("t3_bad_code", K, 0);
      cancel = 1'b1;
      tick();
      check("t3_rv", refund_valid, 1); check("t3_ra", refund_amt, 4);
      tick();

      // Credit 3, cancel with simultaneous coin -> coin dropped
      put_coin(2'b10); put_coin(2'b01);
      check("t4_C3", C, 3);
      cancel = 1'b1; coin_valid = 1'b1; coin_val = 2'b01;
      tick();
      check("t4_rej", coin_reject, 1); check("t4_ra", refund_amt, 3);
      check("t4_C", C, 3); check("t4_rv", refund_valid, 1);
      tick();

      // Ack timeout: no A from dispense stage
      a_en = 1'b0;
      put_coin(2'b10);
      select(3'd2);
      kcnt = K ? 1 : 0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         if (K) kcnt++;
         else   seen = 1'b1;
      end
      check("t5_exit", seen, 1);
      check("t5_kcnt", kcnt, 15);
      check("t5_fault", fault, 1);
      check("t5_rv", refund_valid, 1); check("t5_ra", refund_amt, 2);
`ifdef SALES_COUNTER_EN
      check("t5_sales", sales_cnt, 2);
`endif
      tick();
      check("t5_sticky", fault, 1);
      a_en = 1'b1;

      // Idle timeout refunds credit after 200 quiet cycles
      put_coin(2'b01);
      n = 0;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         tick();
         n++;
         if (refund_valid) seen = 1'b1;
      end
      check("t6_seen", seen, 1);
      check("t6_cycles", n, 200);
      check("t6_ra", refund_amt, 1);
      tick();

      // Async reset in DISPENSE
      put_coin(2'b10);
      select(3'd1);
      check("t7_K", K, 1);
      #2 reset_n = 1'b0;
      #1;
      check("t7_K0", K, 0); check("t7_C0", C, 0); check("t7_fault0", fault, 0);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (refund_valid) seen = 1'b1;
      end
      check("t7_no_refund", seen, 0);
      check("t7_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
